// File: rtl/sdmf_pkg.sv
// sdmf_pkg: shared frame-state encoding and header-register layout for the SDMF reducer
package sdmf_pkg;
  typedef enum logic [2:0] {IDLE, PASS, DROP, DRAIN, WAIT} state_t;
  typedef struct packed {
    logic [7:0] til;
    logic [7:0] sil;
  } hdr_t;
endpackage

// File: rtl/sdmf_axis_reg.sv
// sdmf_axis_reg: one-deep AXI-stream register slice for tdata/tlast
module sdmf_axis_reg #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_last,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_last  <= in_last;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
endmodule

// File: rtl/sdmf_reduce_triple.sv
// sdmf_reduce_triple: forwards SDMF frames whose FDSSI lies in [FDSSI_L, FDSSI_H] with folded time/space headers, drops the rest; SDMF_REDUCE_TAG_EN stamps the window-relative FDSSI into output tdata
module sdmf_reduce_triple
  import sdmf_pkg::*;
#(
  parameter int                       I_FDSSI_WIDTH = 2,
  parameter logic [I_FDSSI_WIDTH-1:0] I_MAX_FDSSI   = 2'b11,
  parameter int                       I_FDSTI_WIDTH = 32,
  parameter int                       I_TOM_WIDTH   = 0,
  parameter int                       I_TOM_OFFSET  = 2,
  parameter int                       I_SOM_OFFSET  = 2,
  parameter int                       I_DATA_WIDTH  = 24,
  parameter int                       O_DATA_WIDTH  = 24,
  parameter int                       O_TAM_WIDTH   = 2,
  parameter int                       O_TAM_OFFSET  = 2,
  parameter int                       I_SMASK_WIDTH = 4,
  parameter int                       AXI_BUS_WIDTH = 32,
  parameter int                       AXI_ADDR_LEN  = 11
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [AXI_ADDR_LEN-1:0]               PN_addr,
  input  logic [I_FDSSI_WIDTH-1:0]              FDSSI_L,
  input  logic [I_FDSSI_WIDTH-1:0]              FDSSI_H,
  input  logic                                  SDMFi_d_EFF,
  input  logic [AXI_ADDR_LEN-1:0]               SDMFi_d_PCF,
  input  logic [I_FDSTI_WIDTH-1:0]              SDMFi_d_FDSTI,
  input  logic [I_FDSSI_WIDTH-1:0]              SDMFi_d_FDSSI,
  input  logic [1:0]                            SDMFi_d_FI_valid,
  input  logic [I_TOM_OFFSET-1:0]               SDMFi_d_STI,
  input  logic [7:0]                            SDMFi_d_TIL,
  input  logic [I_SOM_OFFSET-1:0]               SDMFi_d_SSI,
  input  logic [7:0]                            SDMFi_d_SIL,
  input  logic [1:0]                            SDMFi_d_BI_valid,
  input  logic                                  SDMFi_d_tvalid,
  output logic                                  SDMFi_d_tready,
  input  logic                                  SDMFi_d_tlast,
  input  logic [I_DATA_WIDTH-1:0]               SDMFi_d_tdata,
  input  logic                                  SDMFi_d_frame_valid,
  output logic                                  SDMFi_d_EF_ack,
  output logic [AXI_ADDR_LEN-1:0]               SDMFo_d_PCF,
  output logic [I_FDSTI_WIDTH-I_TOM_WIDTH-1:0]  SDMFo_d_FDSTI,
  output logic                                  SDMFo_d_FI_valid,
  output logic [I_TOM_WIDTH+I_TOM_OFFSET-1:0]   SDMFo_d_STI,
  output logic [7:0]                            SDMFo_d_TIL,
  output logic [I_FDSSI_WIDTH+I_SOM_OFFSET-1:0] SDMFo_d_SSI,
  output logic [7:0]                            SDMFo_d_SIL,
  output logic                                  SDMFo_d_BI_valid,
  output logic                                  SDMFo_d_tvalid,
  input  logic                                  SDMFo_d_tready,
  output logic                                  SDMFo_d_tlast,
  output logic [O_DATA_WIDTH-1:0]               SDMFo_d_tdata,
  output logic                                  SDMFo_d_frame_valid
);
  localparam int STI_W   = I_TOM_WIDTH + I_TOM_OFFSET;
  localparam int FDSTI_W = I_FDSTI_WIDTH - I_TOM_WIDTH;
  state_t state, state_nx;
  hdr_t hdr;
  logic first, start, sel, enter, pass_rdy, slice_ready, in_acc_last, out_acc_last, unused;
  logic [I_FDSSI_WIDTH-1:0] rel;
  logic [O_DATA_WIDTH-1:0] din;
  assign unused = ^{SDMFi_d_FI_valid[1], SDMFi_d_BI_valid[1], SDMFi_d_PCF,
                    32'(AXI_BUS_WIDTH + O_TAM_WIDTH + O_TAM_OFFSET)};
  assign rel   = SDMFi_d_FDSSI - FDSSI_L;
  assign start = SDMFi_d_frame_valid && SDMFi_d_FI_valid[0];
  assign sel   = !SDMFi_d_EFF && SDMFi_d_FDSSI >= FDSSI_L && SDMFi_d_FDSSI <= FDSSI_H &&
                 SDMFi_d_FDSSI <= I_MAX_FDSSI && int'(SDMFi_d_FDSSI) < I_SMASK_WIDTH;
  assign enter = state == IDLE && start && sel;
  // first PASS cycle is the header cycle, so input is held off for it
  assign pass_rdy       = state == PASS && !first;
  assign SDMFi_d_tready = pass_rdy ? slice_ready : state == DROP;
  assign in_acc_last    = SDMFi_d_tvalid && SDMFi_d_tready && SDMFi_d_tlast;
  assign out_acc_last   = SDMFo_d_tvalid && SDMFo_d_tready && SDMFo_d_tlast;
  assign SDMFo_d_TIL    = hdr.til;
  assign SDMFo_d_SIL    = hdr.sil;
  always_comb
    state_nx = state == IDLE  ? (start ? (sel ? PASS : DROP) : IDLE) :
               state == PASS  ? (in_acc_last ? DRAIN : PASS) :
               state == DROP  ? (in_acc_last ? WAIT : DROP) :
               state == DRAIN ? (out_acc_last ? WAIT : DRAIN) :
               (SDMFi_d_frame_valid ? WAIT : IDLE);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state               <= IDLE;
      first               <= 1'b0;
      SDMFi_d_EF_ack      <= 1'b0;
      SDMFo_d_FI_valid    <= 1'b0;
      SDMFo_d_BI_valid    <= 1'b0;
      SDMFo_d_frame_valid <= 1'b0;
      SDMFo_d_PCF         <= '0;
      SDMFo_d_FDSTI       <= '0;
      SDMFo_d_STI         <= '0;
      SDMFo_d_SSI         <= '0;
      hdr                 <= '0;
    end else begin
      state               <= state_nx;
      first               <= enter;
      SDMFi_d_EF_ack      <= in_acc_last;
      SDMFo_d_FI_valid    <= enter;
      SDMFo_d_BI_valid    <= enter && SDMFi_d_BI_valid[0];
      SDMFo_d_frame_valid <= enter || (SDMFo_d_frame_valid && !out_acc_last);
      if (enter) begin
        SDMFo_d_PCF   <= PN_addr;
        SDMFo_d_FDSTI <= FDSTI_W'(SDMFi_d_FDSTI >> I_TOM_WIDTH);
        // low FDSTI bits land above STI_in; with no moved bits this is STI_in alone
        SDMFo_d_STI   <= STI_W'({SDMFi_d_FDSTI, SDMFi_d_STI});
        SDMFo_d_SSI   <= {rel, SDMFi_d_SSI};
        hdr           <= '{til: SDMFi_d_TIL + 8'(I_TOM_WIDTH), sil: SDMFi_d_SIL + 8'(I_FDSSI_WIDTH)};
      end
    end
`ifdef SDMF_REDUCE_TAG_EN
  logic [I_FDSSI_WIDTH-1:0] tag;
  always_ff @(posedge clk or posedge reset)
    if (reset) tag <= '0;
    else if (enter) tag <= rel;
  always_comb begin
    din = O_DATA_WIDTH'(SDMFi_d_tdata);
    din[O_TAM_OFFSET +: O_TAM_WIDTH] = O_TAM_WIDTH'(tag);
  end
`else
  always_comb din = O_DATA_WIDTH'(SDMFi_d_tdata);
`endif
  sdmf_axis_reg #(.W(O_DATA_WIDTH)) u_slice (
    .clk      (clk),
    .reset    (reset),
    .in_valid (SDMFi_d_tvalid && pass_rdy),
    .in_ready (slice_ready),
    .in_last  (SDMFi_d_tlast),
    .in_data  (din),
    .out_valid(SDMFo_d_tvalid),
    .out_ready(SDMFo_d_tready),
    .out_last (SDMFo_d_tlast),
    .out_data (SDMFo_d_tdata)
  );
endmodule

// File: tb/tb_sdmf_reduce_triple.sv
// tb_sdmf_reduce_triple: directed self-checking bench for sdmf_reduce_triple
module tb_sdmf_reduce_triple;
  logic        clk = 0, reset = 1;
  logic [10:0] PN_addr = 11'h5A5;
  logic [1:0]  FDSSI_L = 0, FDSSI_H = 0;
  logic        SDMFi_d_EFF = 0;
  logic [10:0] SDMFi_d_PCF = 11'h123;
  logic [31:0] SDMFi_d_FDSTI = 0;
  logic [1:0]  SDMFi_d_FDSSI = 0, SDMFi_d_FI_valid = 0, SDMFi_d_STI = 0, SDMFi_d_SSI = 0, SDMFi_d_BI_valid = 2'b01;
  logic [7:0]  SDMFi_d_TIL = 0, SDMFi_d_SIL = 0;
  logic        SDMFi_d_tvalid = 0, SDMFi_d_tready, SDMFi_d_tlast = 0;
  logic [23:0] SDMFi_d_tdata = 0;
  logic        SDMFi_d_frame_valid = 0, SDMFi_d_EF_ack;
  logic [10:0] SDMFo_d_PCF;
  logic [31:0] SDMFo_d_FDSTI;
  logic        SDMFo_d_FI_valid, SDMFo_d_BI_valid;
  logic [1:0]  SDMFo_d_STI;
  logic [7:0]  SDMFo_d_TIL, SDMFo_d_SIL;
  logic [3:0]  SDMFo_d_SSI;
  logic        SDMFo_d_tvalid, SDMFo_d_tready = 1, SDMFo_d_tlast;
  logic [23:0] SDMFo_d_tdata;
  logic        SDMFo_d_frame_valid;

  sdmf_reduce_triple dut (
    .clk(clk), .reset(reset), .PN_addr(PN_addr), .FDSSI_L(FDSSI_L), .FDSSI_H(FDSSI_H),
    .SDMFi_d_EFF(SDMFi_d_EFF), .SDMFi_d_PCF(SDMFi_d_PCF), .SDMFi_d_FDSTI(SDMFi_d_FDSTI),
    .SDMFi_d_FDSSI(SDMFi_d_FDSSI), .SDMFi_d_FI_valid(SDMFi_d_FI_valid), .SDMFi_d_STI(SDMFi_d_STI),
    .SDMFi_d_TIL(SDMFi_d_TIL), .SDMFi_d_SSI(SDMFi_d_SSI), .SDMFi_d_SIL(SDMFi_d_SIL),
    .SDMFi_d_BI_valid(SDMFi_d_BI_valid), .SDMFi_d_tvalid(SDMFi_d_tvalid), .SDMFi_d_tready(SDMFi_d_tready),
    .SDMFi_d_tlast(SDMFi_d_tlast), .SDMFi_d_tdata(SDMFi_d_tdata), .SDMFi_d_frame_valid(SDMFi_d_frame_valid),
    .SDMFi_d_EF_ack(SDMFi_d_EF_ack), .SDMFo_d_PCF(SDMFo_d_PCF), .SDMFo_d_FDSTI(SDMFo_d_FDSTI),
    .SDMFo_d_FI_valid(SDMFo_d_FI_valid), .SDMFo_d_STI(SDMFo_d_STI), .SDMFo_d_TIL(SDMFo_d_TIL),
    .SDMFo_d_SSI(SDMFo_d_SSI), .SDMFo_d_SIL(SDMFo_d_SIL), .SDMFo_d_BI_valid(SDMFo_d_BI_valid),
    .SDMFo_d_tvalid(SDMFo_d_tvalid), .SDMFo_d_tready(SDMFo_d_tready), .SDMFo_d_tlast(SDMFo_d_tlast),
    .SDMFo_d_tdata(SDMFo_d_tdata), .SDMFo_d_frame_valid(SDMFo_d_frame_valid)
  );

  int n_chk = 0, n_fail = 0, ack_cnt = 0, fi_cnt = 0, bi_cnt = 0;
  logic [24:0] q[$];
  logic [3:0]  h_ssi;
  logic [1:0]  h_sti;
  logic [31:0] h_fdsti;
  logic [7:0]  h_til, h_sil;
  logic [10:0] h_pcf;
  logic        tog = 0, acc = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (SDMFo_d_tvalid && SDMFo_d_tready) q.push_back({SDMFo_d_tlast, SDMFo_d_tdata});
    if (SDMFi_d_EF_ack) ack_cnt++;
    if (SDMFo_d_BI_valid) bi_cnt++;
    if (SDMFo_d_FI_valid) begin
      fi_cnt++;
      h_ssi = SDMFo_d_SSI; h_sti = SDMFo_d_STI; h_fdsti = SDMFo_d_FDSTI;
      h_til = SDMFo_d_TIL; h_sil = SDMFo_d_SIL; h_pcf = SDMFo_d_PCF;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_d(input logic [23:0] d, input logic [1:0] rel);
`ifdef SDMF_REDUCE_TAG_EN
    d[3:2] = rel;
`endif
    return d;
  endfunction

  task automatic cyc();
    @(negedge clk);
    acc = SDMFi_d_tvalid && SDMFi_d_tready;
    @(posedge clk);
    #1;
    if (tog) SDMFo_d_tready = !SDMFo_d_tready;
  endtask

  task automatic send(input logic [1:0] idx, input logic [31:0] fdsti, input logic pass,
                      input logic [23:0] base, input int n);
    int i = 0, budget = 200, bad = 0, a0 = ack_cnt, f0 = fi_cnt, b0 = bi_cnt;
    logic [1:0] rel = idx - FDSSI_L;
    q.delete();
    SDMFi_d_FDSSI = idx; SDMFi_d_FDSTI = fdsti;
    SDMFi_d_frame_valid = 1; SDMFi_d_FI_valid = 2'b01;
    cyc();
    chk("fv_rise", SDMFo_d_frame_valid, pass);
    chk("fi_pulse", SDMFo_d_FI_valid, pass);
    chk("first_rdy", SDMFi_d_tready, !pass);
    while (i < n && budget > 0) begin
      SDMFi_d_tvalid = 1; SDMFi_d_tdata = base + 24'(i); SDMFi_d_tlast = (i == n - 1);
      cyc();
      budget--;
      if (acc) begin
        if (i == 0 && pass) chk("lat1", SDMFo_d_tvalid, 1);
        i++;
      end
    end
    chk("in_done", i, n);
    SDMFi_d_tvalid = 0; SDMFi_d_tlast = 0;
    repeat (3) cyc();
    SDMFi_d_frame_valid = 0;
    repeat (3) cyc();
    chk("beats", q.size(), pass ? n : 0);
    for (int j = 0; j < q.size(); j++)
      if (q[j] !== {j == n - 1, exp_d(base + 24'(j), rel)}) bad++;
    chk("seq", bad, 0);
    chk("ack", ack_cnt - a0, 1);
    chk("fi_cnt", fi_cnt - f0, pass);
    chk("bi_cnt", bi_cnt - b0, pass);
    chk("fv_fall", SDMFo_d_frame_valid, 0);
  endtask

  initial begin
    repeat (3) cyc();
    chk("rst_tready", SDMFi_d_tready, 0);
    chk("rst_tvalid", SDMFo_d_tvalid, 0);
    chk("rst_fv", SDMFo_d_frame_valid, 0);
    chk("rst_fi", SDMFo_d_FI_valid, 0);
    chk("rst_ack", SDMFi_d_EF_ack, 0);
    chk("rst_pcf", SDMFo_d_PCF, 0);
    chk("rst_tdata", SDMFo_d_tdata, 0);
    reset = 0;
    FDSSI_L = 1; FDSSI_H = 3;
    repeat (2) cyc();
    send(2'd0, 32'd10, 0, 24'h000100, 16);
    send(2'd1, 32'd11, 1, 24'h010000, 16);
    chk("hdr1_ssi", h_ssi, 4'b0000);
    SDMFi_d_STI = 2'b01; SDMFi_d_SSI = 2'b11; SDMFi_d_TIL = 8'd7; SDMFi_d_SIL = 8'd9;
    send(2'd2, 32'd12, 1, 24'h020000, 16);
    chk("hdr2_ssi", h_ssi, 4'b0111);
    chk("hdr2_sti", h_sti, 2'b01);
    chk("hdr2_til", h_til, 8'd7);
    chk("hdr2_sil", h_sil, 8'd11);
    SDMFi_d_STI = 0; SDMFi_d_SSI = 0; SDMFi_d_TIL = 0; SDMFi_d_SIL = 0;
    send(2'd3, 32'd5, 1, 24'h030000, 16);
    chk("hdr3_ssi", h_ssi, 4'b1000);
    chk("hdr3_sti", h_sti, 2'b00);
    chk("hdr3_fdsti", h_fdsti, 32'd5);
    chk("hdr3_til", h_til, 8'd0);
    chk("hdr3_sil", h_sil, 8'd2);
    chk("hdr3_pcf", h_pcf, 11'h5A5);
    tog = 1;
    send(2'd1, 32'd20, 1, 24'h0A0000, 16);
    send(2'd3, 32'd21, 1, 24'h0B0000, 3);
    tog = 0; SDMFo_d_tready = 1;
    send(2'd2, 32'd22, 1, 24'h0C0000, 1);
    SDMFi_d_EFF = 1;
    send(2'd1, 32'd30, 0, 24'h0D0000, 4);
    send(2'd2, 32'd31, 0, 24'h0E0000, 4);
    SDMFi_d_EFF = 0;
    FDSSI_L = 3; FDSSI_H = 1;
    send(2'd2, 32'd40, 0, 24'h0F0000, 5);
    send(2'd3, 32'd41, 0, 24'h100000, 5);
    FDSSI_L = 0; FDSSI_H = 3;
    SDMFi_d_FDSSI = 2'd1; SDMFi_d_frame_valid = 1; SDMFi_d_FI_valid = 2'b01;
    cyc();
    for (int i = 0; i < 4; i++) begin
      SDMFi_d_tvalid = 1; SDMFi_d_tdata = 24'h200000 + 24'(i);
      cyc();
    end
    chk("mid_fv", SDMFo_d_frame_valid, 1);
    #2 reset = 1;
    #1;
    chk("mr_tvalid", SDMFo_d_tvalid, 0);
    chk("mr_tdata", SDMFo_d_tdata, 0);
    chk("mr_fv", SDMFo_d_frame_valid, 0);
    chk("mr_tready", SDMFi_d_tready, 0);
    chk("mr_ssi", SDMFo_d_SSI, 0);
    SDMFi_d_tvalid = 0; SDMFi_d_frame_valid = 0;
    repeat (2) cyc();
    reset = 0;
    cyc();
    send(2'd2, 32'd50, 1, 24'h300000, 16);
    chk("mr_hdr_ssi", h_ssi, 4'b1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
